// File: rtl/control_sequencer.sv
// Microstep sequencer for a small accumulator CPU: T0..T4 fetch/execute plus HALTED.
// Control outputs are combinational decodes of the state, opcode and flags; strobes are gated by step_en.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  input  logic       step_en,
  output logic       pc_out,
  output logic       ram_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       sum_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       ram_in,
  output logic       out_load,
  output logic       flag_load,
  output logic       sub,
  output logic       halt,
  output logic [2:0] t_state
);

  // state   | meaning
  // T0      | fetch: PC onto bus, load MAR
  // T1      | fetch: RAM onto bus, load IR, increment PC
  // T2..T4  | execute microsteps, decoded from opcode
  // HALTED  | processor stopped until reset
  typedef enum logic [2:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    HALTED = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      T0: state_d = T1;
      T1: state_d = T2;
      T2: begin
        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB || opcode == OP_STA)
          state_d = T3;
        else if (opcode == OP_HLT)
          state_d = HALTED;
        else
          state_d = T0;
      end
      T3: state_d = (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
      T4: state_d = T0;
      HALTED: state_d = HALTED;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= T0;
    else if (step_en)
      state_q <= state_d;
  end

  // Raw decode before step_en / reset gating.
  logic d_pc_out, d_ram_out, d_ir_out, d_a_out, d_sum_out;
  logic d_pc_inc, d_pc_load, d_mar_load, d_ir_load, d_a_load, d_b_load;
  logic d_ram_in, d_out_load, d_flag_load, d_sub, d_halt;

  always_comb begin
    d_pc_out    = 1'b0;
    d_ram_out   = 1'b0;
    d_ir_out    = 1'b0;
    d_a_out     = 1'b0;
    d_sum_out   = 1'b0;
    d_pc_inc    = 1'b0;
    d_pc_load   = 1'b0;
    d_mar_load  = 1'b0;
    d_ir_load   = 1'b0;
    d_a_load    = 1'b0;
    d_b_load    = 1'b0;
    d_ram_in    = 1'b0;
    d_out_load  = 1'b0;
    d_flag_load = 1'b0;
    d_sub       = 1'b0;
    d_halt      = 1'b0;
    unique case (state_q)
      T0: begin
        d_pc_out   = 1'b1;
        d_mar_load = 1'b1;
      end
      T1: begin
        d_ram_out = 1'b1;
        d_ir_load = 1'b1;
        d_pc_inc  = 1'b1;
      end
      T2: begin
        unique case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            d_ir_out   = 1'b1;
            d_mar_load = 1'b1;
          end
          OP_LDI: begin
            d_ir_out = 1'b1;
            d_a_load = 1'b1;
          end
          OP_JMP: begin
            d_ir_out  = 1'b1;
            d_pc_load = 1'b1;
          end
          OP_JC: begin
            d_ir_out  = 1'b1;
            d_pc_load = carry_flag;
          end
          OP_JZ: begin
            d_ir_out  = 1'b1;
            d_pc_load = zero_flag;
          end
          OP_OUT: begin
            d_a_out    = 1'b1;
            d_out_load = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        unique case (opcode)
          OP_LDA: begin
            d_ram_out = 1'b1;
            d_a_load  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            d_ram_out = 1'b1;
            d_b_load  = 1'b1;
            d_sub     = (opcode == OP_SUB);
          end
          OP_STA: begin
            d_a_out  = 1'b1;
            d_ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          d_sum_out   = 1'b1;
          d_a_load    = 1'b1;
          d_flag_load = 1'b1;
          d_sub       = (opcode == OP_SUB);
        end
      end
      HALTED: d_halt = 1'b1;
      default: ;
    endcase
  end

  // Reset blanks everything immediately; a paused step keeps bus drivers but drops strobes.
  logic drv_ok, stb_ok;
  assign drv_ok = rst_n;
  assign stb_ok = rst_n & step_en;

  assign pc_out    = d_pc_out    & drv_ok;
  assign ram_out   = d_ram_out   & drv_ok;
  assign ir_out    = d_ir_out    & drv_ok;
  assign a_out     = d_a_out     & drv_ok;
  assign sum_out   = d_sum_out   & drv_ok;
  assign sub       = d_sub       & drv_ok;
  assign halt      = d_halt      & drv_ok;
  assign pc_inc    = d_pc_inc    & stb_ok;
  assign pc_load   = d_pc_load   & stb_ok;
  assign mar_load  = d_mar_load  & stb_ok;
  assign ir_load   = d_ir_load   & stb_ok;
  assign a_load    = d_a_load    & stb_ok;
  assign b_load    = d_b_load    & stb_ok;
  assign ram_in    = d_ram_in    & stb_ok;
  assign out_load  = d_out_load  & stb_ok;
  assign flag_load = d_flag_load & stb_ok;
  assign t_state   = rst_n ? state_q : 3'd0;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expected outputs are queued
// from an instruction-length/microcode model and compared against the DUT.
module tb_control_sequencer;

  logic       clk, rst_n;
  logic [3:0] opcode;
  logic       carry_flag, zero_flag, step_en;
  logic       pc_out, ram_out, ir_out, a_out, sum_out;
  logic       pc_inc, pc_load, mar_load, ir_load, a_load, b_load;
  logic       ram_in, out_load, flag_load, sub, halt;
  logic [2:0] t_state;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .step_en(step_en),
    .pc_out(pc_out), .ram_out(ram_out), .ir_out(ir_out), .a_out(a_out), .sum_out(sum_out),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load), .ir_load(ir_load),
    .a_load(a_load), .b_load(b_load), .ram_in(ram_in), .out_load(out_load),
    .flag_load(flag_load), .sub(sub), .halt(halt), .t_state(t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_out,ram_out,ir_out,a_out,sum_out,pc_inc,pc_load,mar_load,ir_load,a_load,b_load,ram_in,out_load,flag_load,sub,halt}
  logic [15:0] act_vec;
  assign act_vec = {pc_out, ram_out, ir_out, a_out, sum_out, pc_inc, pc_load, mar_load,
                    ir_load, a_load, b_load, ram_in, out_load, flag_load, sub, halt};

  typedef struct packed {
    logic [2:0]  t;
    logic [15:0] o;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_st = 0;

  // Microcode as literal bit positions (15 = pc_out ... 0 = halt).
  function automatic logic [15:0] model_out(int st, logic [3:0] op, logic c, logic z, logic en);
    logic [15:0] drv, stb;
    drv = '0;
    stb = '0;
    case (st)
      0: begin drv[15] = 1; stb[8] = 1; end
      1: begin drv[14] = 1; stb[7] = 1; stb[10] = 1; end
      2: case (op)
           4'h1, 4'h2, 4'h3, 4'h4: begin drv[13] = 1; stb[8] = 1; end
           4'h5: begin drv[13] = 1; stb[6] = 1; end
           4'h6: begin drv[13] = 1; stb[9] = 1; end
           4'h7: begin drv[13] = 1; stb[9] = c; end
           4'h8: begin drv[13] = 1; stb[9] = z; end
           4'hE: begin drv[12] = 1; stb[3] = 1; end
           default: ;
         endcase
      3: case (op)
           4'h1: begin drv[14] = 1; stb[6] = 1; end
           4'h2: begin drv[14] = 1; stb[5] = 1; end
           4'h3: begin drv[14] = 1; stb[5] = 1; drv[1] = 1; end
           4'h4: begin drv[12] = 1; stb[4] = 1; end
           default: ;
         endcase
      4: if (op == 4'h2 || op == 4'h3) begin
           drv[11] = 1; stb[6] = 1; stb[2] = 1; drv[1] = (op == 4'h3);
         end
      7: drv[0] = 1;
      default: ;
    endcase
    return drv | (en ? stb : 16'h0);
  endfunction

  function automatic int model_next(int st, logic [3:0] op);
    int len;
    if (st == 7) return 7;
    if (st == 2 && op == 4'hF) return 7;
    case (op)
      4'h1, 4'h4: len = 4;
      4'h2, 4'h3: len = 5;
      default:    len = 3;
    endcase
    return (st + 1 >= len) ? 0 : st + 1;
  endfunction

  // One clock cycle: called just after a falling edge, leaves just after the next one.
  task automatic cyc(input string name, input logic [3:0] op, input logic c, input logic z, input logic en);
    exp_t e, got;
    opcode = op; carry_flag = c; zero_flag = z; step_en = en;
    e.t = 3'(model_st);
    e.o = model_out(model_st, op, c, z, en);
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    total++;
    if (t_state !== got.t || act_vec !== got.o) begin
      bad++;
      $display("FAIL %s: t_state=%0d outs=%b expected t_state=%0d outs=%b (op=%h c=%b z=%b en=%b)",
               name, t_state, act_vec, got.t, got.o, op, c, z, en);
    end
    total++;
    if ($countones(act_vec[15:11]) > 1) begin
      bad++;
      $display("FAIL %s_bus_onehot: drivers=%b expected at most one set", name, act_vec[15:11]);
    end
    @(posedge clk);
    if (en) model_st = model_next(model_st, op);
    @(negedge clk);
  endtask

  task automatic reset_mid_cycle(input string name);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (t_state !== 3'd0 || act_vec !== 16'h0) begin
      bad++;
      $display("FAIL %s_async: t_state=%0d outs=%b expected t_state=0 outs=0", name, t_state, act_vec);
    end
    @(posedge clk);
    #1;
    total++;
    if (t_state !== 3'd0 || act_vec !== 16'h0) begin
      bad++;
      $display("FAIL %s_held: t_state=%0d outs=%b expected t_state=0 outs=0", name, t_state, act_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_st = 0;
  endtask

  task automatic test_reset();
    reset_mid_cycle("reset");
    cyc("reset_t0", 4'h0, 0, 0, 1);
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic c, input logic z, input int n);
    for (int i = 0; i < n; i++) cyc(name, op, c, z, 1);
  endtask

  task automatic test_add();
    run_instr("add", 4'h2, 0, 0, 5);
    cyc("add_back_t0", 4'h2, 0, 0, 1);
    run_instr("add_tail", 4'h2, 0, 0, 4);
  endtask

  task automatic test_sub();
    run_instr("sub", 4'h3, 1, 0, 5);
    cyc("sub_back_t0", 4'h0, 0, 0, 1);
    run_instr("sub_nop", 4'h0, 0, 0, 2);
  endtask

  task automatic test_jumps();
    run_instr("jc_nc", 4'h7, 0, 1, 3);
    run_instr("jc_c", 4'h7, 1, 0, 3);
    run_instr("jz_nz", 4'h8, 1, 0, 3);
    run_instr("jz_z", 4'h8, 0, 1, 3);
    run_instr("jmp", 4'h6, 0, 0, 3);
    cyc("jc_t0", 4'h7, 0, 0, 1);
    cyc("jc_t1", 4'h7, 0, 0, 1);
    cyc("jc_flagflip_t2", 4'h7, 1, 0, 1);
  endtask

  task automatic test_misc_ops();
    run_instr("ldi", 4'h5, 0, 0, 3);
    run_instr("sta", 4'h4, 0, 0, 4);
    run_instr("out", 4'hE, 0, 0, 3);
    run_instr("undef_9", 4'h9, 1, 1, 3);
    run_instr("undef_c", 4'hC, 1, 1, 3);
    run_instr("nop", 4'h0, 0, 0, 3);
  endtask

  task automatic test_lda_pause();
    run_instr("lda_fetch", 4'h1, 0, 0, 3);
    for (int i = 0; i < 4; i++) cyc("lda_pause", 4'h1, 0, 0, 0);
    cyc("lda_resume", 4'h1, 0, 0, 1);
    cyc("lda_t0", 4'h1, 0, 0, 1);
    cyc("lda_pause_t1", 4'h1, 0, 0, 0);
    run_instr("lda_finish", 4'h1, 0, 0, 3);
  endtask

  task automatic test_halt();
    run_instr("hlt", 4'hF, 0, 0, 3);
    for (int i = 0; i < 12; i++)
      cyc("halted", 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'(i % 2));
    reset_mid_cycle("halt_reset");
    cyc("halt_after_reset", 4'h1, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 10000; i++) begin
      if (model_st == 7 && $urandom_range(0, 3) == 0) reset_mid_cycle("rand_reset");
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hA;
      cyc("random", op, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 4'h0; carry_flag = 0; zero_flag = 0; step_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_jumps();
    test_misc_ops();
    test_lda_pause();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous reset, active low.
REQ-004 opcode  in  4  instruction register upper nibble.
REQ-005 carry_flag, zero_flag  in  1 each  latched flags.
REQ-006 step_en  in  1  advance enable; 0 = hold (single-step / pause).
REQ-007 pc_out, ram_out, ir_out, a_out, sum_out  out  1 each  bus-drive enables, active high. sum_out drives the adder/subtractor out_en.
REQ-008 pc_inc, pc_load, mar_load, ir_load, a_load, b_load, ram_in, out_load, flag_load  out  1 each  load/increment strobes, active high.
REQ-009 sub  out  1  adder/subtractor mode: 1 = A-B, 0 = A+B.
REQ-010 halt  out  1  processor halted.
REQ-011 t_state  out  3  current microstep: 0..4 = T0..T4, 7 = HALTED.

Function
REQ-012 State register SHALL take the values T0..T4 and HALTED, and SHALL advance on a rising clk edge only when step_en=1.
REQ-013 When step_en=0, state SHALL hold; bus-drive enables SHALL follow the state, and all strobes plus flag_load SHALL be forced 0.
REQ-014 All control outputs SHALL be combinational decodes of state, opcode and flags. No output SHALL depend on step_en except through REQ-013.
REQ-015 Fetch is opcode-independent:
- T0: pc_out, mar_load.
- T1: ram_out, ir_load, pc_inc.
REQ-016 Execute steps by opcode (unlisted signals 0; "->T0" = next state after this step):
- 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load ->T0.
- 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 sum_out+a_load+flag_load, sub=0 ->T0.
- 0x3 SUB: as ADD, with sub=1 in T3 and T4.
- 0x4 STA: T2 ir_out+mar_load; T3 a_out+ram_in ->T0.
- 0x5 LDI: T2 ir_out+a_load ->T0.
- 0x6 JMP: T2 ir_out+pc_load ->T0.
- 0x7 JC: T2 ir_out, plus pc_load only if carry_flag=1 ->T0.
- 0x8 JZ: T2 ir_out, plus pc_load only if zero_flag=1 ->T0.
- 0xE OUT: T2 a_out+out_load ->T0.
- 0xF HLT: T2 no strobes ->HALTED.
- 0x0 and all other codes are NOP: T2 no strobes ->T0.
REQ-017 Instruction lengths SHALL be: NOP/LDI/JMP/JC/JZ/OUT 3 cycles; LDA/STA 4 cycles; ADD/SUB 5 cycles; HLT 3 cycles to HALTED.
REQ-018 At most one of pc_out, ram_out, ir_out, a_out, sum_out SHALL be 1 in any state.
REQ-019 In HALTED: halt=1, t_state=7, all other outputs 0. State SHALL remain HALTED regardless of step_en and opcode until reset.
REQ-020 JC/JZ SHALL sample the flags combinationally during T2. A flag change in the same cycle SHALL affect only that cycle's pc_load.
REQ-021 sub SHALL be 0 in every state not listed in REQ-016.

Reset
REQ-022 While rst_n=0: state=T0, t_state=0, halt=0, and every control output SHALL be 0, overriding the REQ-015 T0 decode.
REQ-023 Reset assertion SHALL take effect immediately, mid-instruction or in HALTED, without waiting for clk.
REQ-024 After rst_n rises, the first rising edge with step_en=1 SHALL leave T0. T0 decode (pc_out, mar_load) SHALL be visible from rst_n deassertion.

Verification
REQ-025 Reset, step_en=1, opcode=0x2: t_state sequence 0,1,2,3,4,0. sum_out=a_load=flag_load=1 only in T4, sub=0 throughout.
REQ-026 opcode=0x3: sub=1 in T3 and T4 only. In T4 exactly one bus driver (sum_out) is active.
REQ-027 opcode=0x7 with carry_flag=0: T2 pc_load=0, return to T0 after 3 cycles. Repeat with carry_flag=1: T2 pc_load=1.
REQ-028 step_en=0 for 4 cycles while in T3 of LDA: t_state stays 3, ram_out=1, a_load=0. Restore step_en: a_load=1 for one cycle, then T0.
REQ-029 opcode=0xF: after T2, halt=1 and t_state=7, held 10+ cycles with opcode and step_en toggling. Assert rst_n=0 between clock edges: halt=0 and all outputs 0 immediately.
REQ-030 Random opcode/flag/step_en stream, 10k cycles: at most one bus driver every cycle, and undefined opcodes always take 3 cycles with no strobes in T2.
